// File: rtl/dro_seq_pkg.sv
// Shared types and defaults for the DRO pulse sequencer (cmd opcodes, FSM states).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dro_seq_pkg;

    localparam int DEPTH_DEF   = 4;
    localparam int GAP_W_DEF   = 8;
    localparam int MIN_GAP_DEF = 3;

    // Opcode 3 is reserved and behaves exactly like NOP.
    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_SET  = 2'd1,
        OP_READ = 2'd2,
        OP_RSVD = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } seq_state_e;

    // True for opcodes that put an edge on one of the DRO lines.
    function automatic logic emits_edge(cmd_op_e op);
        return (op == OP_SET) || (op == OP_READ);
    endfunction

endpackage

// File: rtl/dro_pulse_sequencer_if.sv
// Command bus into the DRO pulse sequencer (valid/ready handshake, opcode, gap).
// Latency: n/a (wires only).
// Backpressure: cmd_ready low means the command FIFO is full; the master holds its command.
interface dro_pulse_sequencer_if #(
    parameter int GAP_W = dro_seq_pkg::GAP_W_DEF
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [GAP_W-1:0] cmd_gap;

    modport master (output cmd_valid, output cmd_op, output cmd_gap, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_gap, output cmd_ready);
endinterface

// File: rtl/dro_seq_cmd_fifo.sv
// Command FIFO for the DRO sequencer: DEPTH entries, strict first-in first-out.
// Latency: head visible combinationally the cycle after the push edge.
// Backpressure: full is taken from the registered count; a push while full is dropped even if a pop happens that cycle.
module dro_seq_cmd_fifo #(
    parameter int DEPTH = dro_seq_pkg::DEPTH_DEF,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/dro_pulse_sequencer.sv
// DRO pulse sequencer: queues SET/READ/NOP commands and emits one toggle per edge command with a hold-margin gap; DRO_SEQ_EXPECT_EN adds an expected-state model.
// Latency: command accepted at edge k into an idle, empty sequencer toggles its line after edge k+2.
// Backpressure: cmd_ready = !full of the DEPTH-entry command FIFO; commands drain at most one per ISSUE.
module dro_pulse_sequencer
    import dro_seq_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int GAP_W   = GAP_W_DEF,
    parameter int MIN_GAP = MIN_GAP_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    dro_pulse_sequencer_if.slave  cmd,
    output logic                  dro_set,
    output logic                  dro_reset,
    output logic                  busy
`ifdef DRO_SEQ_EXPECT_EN
    ,
    output logic                  exp_state,
    output logic                  exp_out
`endif
);
    localparam int               FW        = 2 + GAP_W;
    localparam logic [GAP_W-1:0] MIN_GAP_G = GAP_W'(MIN_GAP);

    seq_state_e       state;
    seq_state_e       state_nxt;
    logic [GAP_W-1:0] wait_cnt;
    logic [GAP_W-1:0] wait_cnt_nxt;
    cmd_op_e          cur_op;
    logic [GAP_W-1:0] cur_gap;
    logic             pop;
    logic             set_tgl;
    logic             rst_tgl;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FW-1:0]    head_dat;

    dro_seq_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (cmd.cmd_valid),
        .push_dat ({cmd.cmd_op, cmd.cmd_gap}),
        .full     (fifo_full),
        .pop      (pop),
        .pop_dat  (head_dat),
        .empty    (fifo_empty)
    );

    assign cmd.cmd_ready = !fifo_full;
    assign busy          = !fifo_empty || (state != ST_IDLE);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state, FIFO pop, toggle requests and next wait count.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        pop          = 1'b0;
        set_tgl      = 1'b0;
        rst_tgl      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                set_tgl = (cur_op == OP_SET);
                rst_tgl = (cur_op == OP_READ);
                // Edges get at least MIN_GAP idle cycles; NOPs take their gap verbatim.
                if (emits_edge(cur_op) && (cur_gap < MIN_GAP_G)) wait_cnt_nxt = MIN_GAP_G;
                else                                               wait_cnt_nxt = cur_gap;
                state_nxt = (wait_cnt_nxt == '0) ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                wait_cnt_nxt = wait_cnt - GAP_W'(1);
                if (wait_cnt_nxt == '0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: wait counter, popped command and the DRO lines.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt  <= '0;
            cur_op    <= OP_NOP;
            cur_gap   <= '0;
            dro_set   <= 1'b0;
            dro_reset <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
            if (pop) begin
                cur_op  <= cmd_op_e'(head_dat[FW-1 -: 2]);
                cur_gap <= head_dat[GAP_W-1:0];
            end
            if (set_tgl) dro_set   <= ~dro_set;
            if (rst_tgl) dro_reset <= ~dro_reset;
        end
    end

`ifdef DRO_SEQ_EXPECT_EN
    // Expected DRO model, advanced on the ISSUE edge: SET stores a 1, READ of a 1 flips the output and clears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_state <= 1'b0;
            exp_out   <= 1'b0;
        end else if (state == ST_ISSUE) begin
            if (cur_op == OP_SET && !exp_state) begin
                exp_state <= 1'b1;
            end else if (cur_op == OP_READ && exp_state) begin
                exp_state <= 1'b0;
                exp_out   <= ~exp_out;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dro_pulse_sequencer.sv
// Self-checking bench for dro_pulse_sequencer: scoreboard of expected toggles plus directed timing checks.
// Latency: checks the k+2 toggle latency, MIN_GAP spacing, FIFO backpressure and reset flush.
// Backpressure: drives cmd_valid and holds it until cmd_ready was high at the accepting edge.
module tb_dro_pulse_sequencer;
    import dro_seq_pkg::*;

    localparam int GAP_W   = 8;
    localparam int MIN_GAP = 3;
    localparam int DEPTH   = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dro_pulse_sequencer_if #(.GAP_W(GAP_W)) cmd_if ();
    logic dro_set;
    logic dro_reset;
    logic busy;
`ifdef DRO_SEQ_EXPECT_EN
    logic exp_state;
    logic exp_out;
`endif

    dro_pulse_sequencer #(
        .DEPTH   (DEPTH),
        .GAP_W   (GAP_W),
        .MIN_GAP (MIN_GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd       (cmd_if),
        .dro_set   (dro_set),
        .dro_reset (dro_reset),
        .busy      (busy)
`ifdef DRO_SEQ_EXPECT_EN
        ,
        .exp_state (exp_state),
        .exp_out   (exp_out)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Scoreboard: kind 1 = dro_set toggle, 2 = dro_reset toggle; eo = expected exp_out afterwards.
    typedef struct {
        int   kind;
        logic eo;
    } sb_t;
    sb_t sb_q[$];
    bit  m_state = 1'b0;
    bit  m_out   = 1'b0;

    task automatic sb_expect(input logic [1:0] op);
        sb_t e;
        if (op == 2'd1) begin
            if (!m_state) m_state = 1'b1;
            e.kind = 1; e.eo = m_out;
            sb_q.push_back(e);
        end else if (op == 2'd2) begin
            if (m_state) begin m_out = ~m_out; m_state = 1'b0; end
            e.kind = 2; e.eo = m_out;
            sb_q.push_back(e);
        end
    endtask

    // Monitor: detect toggles at the falling edge and pop the scoreboard.
    logic prev_set = 1'b0;
    logic prev_rst = 1'b0;
    int   cyc = 0;
    int   last_edge = 0;
    bit   have_last = 1'b0;
    int   n_set_tgl = 0;
    int   n_rst_tgl = 0;
    always @(negedge clk) begin
        int  k;
        sb_t e;
        cyc++;
        if (reset) begin
            have_last = 1'b0;
        end else begin
            k = 0;
            if (dro_set !== prev_set) begin k = k + 1; n_set_tgl++; end
            if (dro_reset !== prev_rst) begin k = k + 2; n_rst_tgl++; end
            if (k != 0) begin
                if (have_last) check_eq("edge_spacing_ok", 32'(cyc - last_edge >= MIN_GAP + 2), 1);
                have_last = 1'b1;
                last_edge = cyc;
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_toggle", k, 0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("toggle_kind", k, e.kind);
`ifdef DRO_SEQ_EXPECT_EN
                    check_eq("exp_out", 32'(exp_out), 32'(e.eo));
`endif
                end
            end
        end
        prev_set = dro_set;
        prev_rst = dro_reset;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle send; the FIFO is known to have room.
    task automatic send_now(input logic [1:0] op, input logic [GAP_W-1:0] gap);
        check_eq("ready_before_send", 32'(cmd_if.cmd_ready), 1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_gap   = gap;
        tick();
        cmd_if.cmd_valid = 1'b0;
        sb_expect(op);
    endtask

    // Hold the command until accepted; stalls = cycles spent before the accepting edge.
    task automatic push_cmd(input logic [1:0] op, input logic [GAP_W-1:0] gap, output int stalls);
        bit ok = 1'b0;
        bit rdy;
        stalls = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_gap   = gap;
        for (int i = 0; i < 300; i++) begin
            rdy = cmd_if.cmd_ready;
            tick();
            if (rdy) begin ok = 1'b1; break; end
            stalls++;
        end
        cmd_if.cmd_valid = 1'b0;
        if (ok) sb_expect(op);
        else    check_eq("push_timeout", 0, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 2000) begin tick(); n++; end
        if (busy) check_eq({tag, "_idle_timeout"}, 0, 1);
        tick();
        check_eq({tag, "_sb_drained"}, sb_q.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb_q.delete();
        m_state = 1'b0;
        m_out   = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int stalls;
        int s0;
        int r0;
        int n;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'd0;
        cmd_if.cmd_gap   = '0;

        // Reset state
        #1 reset = 1'b1;
        #1;
        check_eq("rst_dro_set", 32'(dro_set), 0);
        check_eq("rst_dro_reset", 32'(dro_reset), 0);
        check_eq("rst_cmd_ready", 32'(cmd_if.cmd_ready), 1);
        check_eq("rst_busy", 32'(busy), 0);
`ifdef DRO_SEQ_EXPECT_EN
        check_eq("rst_exp_state", 32'(exp_state), 0);
        check_eq("rst_exp_out", 32'(exp_out), 0);
`endif
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();

        // Latency and minimum gap: SET at edge k toggles after k+2; READ follows no earlier than k+7.
        send_now(2'd1, 8'd0);
        check_eq("busy_after_accept", 32'(busy), 1);
        tick();
        check_eq("set_not_at_k1", 32'(dro_set), 0);
        tick();
        check_eq("set_at_k2", 32'(dro_set), 1);
        send_now(2'd2, 8'd0);
        repeat (3) tick();
        check_eq("read_not_at_k6", 32'(dro_reset), 0);
        tick();
        check_eq("read_at_k7", 32'(dro_reset), 1);
        wait_idle("lat");

        // SET, READ, READ, SET, READ with gap 0
        do_reset();
        s0 = n_set_tgl;
        r0 = n_rst_tgl;
        push_cmd(2'd1, 8'd0, stalls);
        push_cmd(2'd2, 8'd0, stalls);
        push_cmd(2'd2, 8'd0, stalls);
        push_cmd(2'd1, 8'd0, stalls);
        push_cmd(2'd2, 8'd0, stalls);
        wait_idle("seq");
        check_eq("seq_set_toggles", n_set_tgl - s0, 2);
        check_eq("seq_rst_toggles", n_rst_tgl - r0, 3);
`ifdef DRO_SEQ_EXPECT_EN
        check_eq("seq_final_exp_out", 32'(exp_out), 0);
`endif

        // Backpressure: FSM held in WAIT by gap 20, four queued, fifth stalls until the next pop.
        send_now(2'd1, 8'd20);
        repeat (2) tick();
        send_now(2'd2, 8'd0);
        send_now(2'd1, 8'd0);
        send_now(2'd2, 8'd0);
        send_now(2'd0, 8'd1);
        check_eq("full_ready_low", 32'(cmd_if.cmd_ready), 0);
        push_cmd(2'd1, 8'd0, stalls);
        check_eq("fifth_stall_cycles", stalls, 17);
        wait_idle("bp");

        // NOP gap 0: no toggle, idle two edges after acceptance.
        s0 = n_set_tgl;
        r0 = n_rst_tgl;
        send_now(2'd0, 8'd0);
        tick();
        check_eq("nop0_busy_issue", 32'(busy), 1);
        tick();
        check_eq("nop0_idle", 32'(busy), 0);
        // Reserved opcode behaves as NOP.
        send_now(2'd3, 8'd0);
        repeat (2) tick();
        check_eq("rsvd_idle", 32'(busy), 0);

        // NOP gap 255: busy for exactly 256 cycles counted from the pop edge.
        send_now(2'd0, 8'd255);
        tick();
        n = 0;
        while (busy && n < 400) begin tick(); n++; end
        check_eq("nop255_busy_cycles", n, 256);
        check_eq("nop_no_set_toggle", n_set_tgl - s0, 0);
        check_eq("nop_no_rst_toggle", n_rst_tgl - r0, 0);

        // Reset during WAIT with three queued.
        send_now(2'd1, 8'd20);
        repeat (2) tick();
        send_now(2'd2, 8'd0);
        send_now(2'd1, 8'd0);
        send_now(2'd2, 8'd0);
        check_eq("pre_rst_busy", 32'(busy), 1);
        reset = 1'b1;
        sb_q.delete();
        m_state = 1'b0;
        m_out   = 1'b0;
        #1;
        check_eq("midrst_dro_set", 32'(dro_set), 0);
        check_eq("midrst_dro_reset", 32'(dro_reset), 0);
        check_eq("midrst_cmd_ready", 32'(cmd_if.cmd_ready), 1);
        check_eq("midrst_busy", 32'(busy), 0);
`ifdef DRO_SEQ_EXPECT_EN
        check_eq("midrst_exp_out", 32'(exp_out), 0);
`endif
        repeat (2) tick();
        reset = 1'b0;
        s0 = n_set_tgl;
        r0 = n_rst_tgl;
        repeat (40) tick();
        check_eq("postrst_no_set_toggle", n_set_tgl - s0, 0);
        check_eq("postrst_no_rst_toggle", n_rst_tgl - r0, 0);
        check_eq("postrst_busy", 32'(busy), 0);

        // A fresh command still works after the flush.
        send_now(2'd1, 8'd0);
        wait_idle("post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
